// File: rtl/issue_stage_pkg.sv
// Shared constants and types for the out-of-order issue stage.
package issue_stage_pkg;
  localparam int ROB_DEPTH = 8;
  localparam int ROB_IW    = 3;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_MUL  = 4'h2;
  localparam logic [3:0] OP_DIV  = 4'h3;
  localparam logic [3:0] OP_LOAD = 4'h4;
  localparam logic [3:0] OP_STORE = 4'h5;
  localparam logic [3:0] OP_BEQ  = 4'h6;
  localparam logic [3:0] OP_BNEQ = 4'h7;

  localparam logic [1:0] CLS_ADD = 2'd0;
  localparam logic [1:0] CLS_MUL = 2'd1;
  localparam logic [1:0] CLS_LS  = 2'd2;
  localparam logic [1:0] CLS_BR  = 2'd3;

  localparam logic [2:0] CAP_ADD = 3'd3;
  localparam logic [2:0] CAP_MUL = 3'd3;
  localparam logic [2:0] CAP_LS  = 3'd4;
  localparam logic [2:0] CAP_BR  = 3'd2;

  // Operand as handed to a reservation station.
  typedef struct packed {
    logic [15:0]       v;
    logic [ROB_IW-1:0] q;
    logic              r;
  } opnd_t;

  // Illegal opcodes still map to a class so in_ready stays legality-blind.
  function automatic logic [1:0] op_class(input logic [3:0] f);
    case (f)
      OP_ADD, OP_SUB:    op_class = CLS_ADD;
      OP_MUL, OP_DIV:    op_class = CLS_MUL;
      OP_LOAD, OP_STORE: op_class = CLS_LS;
      OP_BEQ, OP_BNEQ:   op_class = CLS_BR;
      default:           op_class = f[2:1];
    endcase
  endfunction

  function automatic logic [2:0] cls_cap(input logic [1:0] c);
    case (c)
      CLS_ADD: cls_cap = CAP_ADD;
      CLS_MUL: cls_cap = CAP_MUL;
      CLS_LS:  cls_cap = CAP_LS;
      default: cls_cap = CAP_BR;
    endcase
  endfunction
endpackage

// File: rtl/issue_stage_rob.sv
// Circular 8-entry reorder buffer: allocate at tail, CDB completion, in-order pop.
module issue_stage_rob
  import issue_stage_pkg::*;
(
  input  logic              i_clk1,
  input  logic              i_rst,
  input  logic              i_alloc,
  input  logic [3:0]        i_alloc_dest,
  input  logic              i_alloc_hasd,
  input  logic              i_cdb_valid,
  input  logic [ROB_IW-1:0] i_cdb_tag,
  input  logic [15:0]       i_cdb_data,
  input  logic [ROB_IW-1:0] i_tag_j,
  input  logic [ROB_IW-1:0] i_tag_k,
  output logic              o_full,
  output logic [ROB_IW-1:0] o_tail,
  output logic [ROB_IW-1:0] o_head,
  output logic              o_pop,
  output logic [3:0]        o_head_dest,
  output logic              o_head_hasd,
  output logic [15:0]       o_head_val,
  output logic              o_done_j,
  output logic              o_done_k,
  output logic [15:0]       o_val_j,
  output logic [15:0]       o_val_k
);
  logic [ROB_DEPTH-1:0][3:0]  r_dest;
  logic [ROB_DEPTH-1:0]       r_hasd;
  logic [ROB_DEPTH-1:0]       r_done;
  logic [ROB_DEPTH-1:0][15:0] r_val;
  logic [ROB_IW-1:0]          r_head, r_tail;
  logic [ROB_IW:0]            r_count;

  assign o_full      = (r_count == (ROB_IW+1)'(ROB_DEPTH));
  assign o_tail      = r_tail;
  assign o_head      = r_head;
  assign o_pop       = r_done[r_head] & (r_count != '0);
  assign o_head_dest = r_dest[r_head];
  assign o_head_hasd = r_hasd[r_head];
  assign o_head_val  = r_val[r_head];
  assign o_done_j    = r_done[i_tag_j];
  assign o_done_k    = r_done[i_tag_k];
  assign o_val_j     = r_val[i_tag_j];
  assign o_val_k     = r_val[i_tag_k];

  // Allocation clears done, so a popped slot never needs explicit scrubbing.
  always_ff @(posedge i_clk1) begin
    if (i_rst) begin
      r_dest  <= '0;
      r_hasd  <= '0;
      r_done  <= '0;
      r_val   <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (i_alloc) begin
        r_dest[r_tail] <= i_alloc_dest;
        r_hasd[r_tail] <= i_alloc_hasd;
        r_done[r_tail] <= 1'b0;
        r_tail         <= r_tail + 1'b1;
      end
      if (i_cdb_valid) begin
        r_done[i_cdb_tag] <= 1'b1;
        r_val[i_cdb_tag]  <= i_cdb_data;
      end
      if (o_pop) r_head <= r_head + 1'b1;
      r_count <= r_count + {{ROB_IW{1'b0}}, i_alloc} - {{ROB_IW{1'b0}}, o_pop};
    end
  end
endmodule

// File: rtl/issue_stage.sv
// Issue stage: decode, class-capacity check, operand read/rename, ROB allocate and commit.
module issue_stage
  import issue_stage_pkg::*;
(
  input  logic        i_clk1,
  input  logic        i_rst,
  input  logic        i_in_valid,
  input  logic [3:0]  i_in_func,
  input  logic [3:0]  i_in_rs1,
  input  logic [3:0]  i_in_rs2,
  input  logic [3:0]  i_in_rd,
  output logic        o_in_ready,
  input  logic [3:0]  i_release,
  input  logic        i_cdb_valid,
  input  logic [2:0]  i_cdb_tag,
  input  logic [15:0] i_cdb_data,
  output logic        o_iss_valid,
  output logic [1:0]  o_iss_class,
  output logic [3:0]  o_iss_func,
  output logic [2:0]  o_iss_rob,
  output logic [3:0]  o_iss_rd,
  output logic [15:0] o_iss_vj,
  output logic [15:0] o_iss_vk,
  output logic [2:0]  o_iss_qj,
  output logic [2:0]  o_iss_qk,
  output logic        o_iss_rj,
  output logic        o_iss_rk,
  output logic        o_commit_valid,
  output logic [3:0]  o_commit_rd,
  output logic [15:0] o_commit_data,
  output logic        o_illegal
);
  logic [15:0][15:0]       r_rf_val;
  logic [15:0]             r_rf_busy;
  logic [15:0][ROB_IW-1:0] r_rf_tag;
  logic [3:0][2:0]         r_cnt;

  logic [1:0]        w_cls;
  logic              w_legal, w_acc, w_hasd, w_is_ls, w_is_ld, w_is_st, w_commit_wr;
  logic [3:0]        w_src_k, w_inc;
  logic              w_rob_full, w_pop, w_head_hasd, w_done_j, w_done_k;
  logic [ROB_IW-1:0] w_tail, w_head;
  logic [3:0]        w_head_dest;
  logic [15:0]       w_head_val, w_val_j, w_val_k;
  opnd_t             w_opj, w_opk;

  assign w_cls      = op_class(i_in_func);
  assign w_legal    = ~i_in_func[3];
  assign w_is_ls    = (w_cls == CLS_LS);
  assign w_is_ld    = (i_in_func == OP_LOAD);
  assign w_is_st    = (i_in_func == OP_STORE);
  assign o_in_ready = (r_cnt[w_cls] < cls_cap(w_cls)) & ~w_rob_full;
  assign w_acc      = i_in_valid & o_in_ready & w_legal;
  assign w_hasd     = w_legal & ((w_cls == CLS_ADD) | (w_cls == CLS_MUL) | w_is_ld);
  assign w_src_k    = w_is_st ? i_in_rd : i_in_rs2;
  assign w_inc      = w_acc ? (4'b0001 << w_cls) : 4'b0000;
  // A same-cycle rename of the retiring register keeps it busy under the new tag.
  assign w_commit_wr = w_pop & w_head_hasd & r_rf_busy[w_head_dest]
                     & (r_rf_tag[w_head_dest] == w_head)
                     & ~(w_acc & w_hasd & (i_in_rd == w_head_dest));

  issue_stage_rob u_rob (
    .i_clk1(i_clk1), .i_rst(i_rst),
    .i_alloc(w_acc), .i_alloc_dest(i_in_rd), .i_alloc_hasd(w_hasd),
    .i_cdb_valid(i_cdb_valid), .i_cdb_tag(i_cdb_tag), .i_cdb_data(i_cdb_data),
    .i_tag_j(r_rf_tag[i_in_rs1]), .i_tag_k(r_rf_tag[w_src_k]),
    .o_full(w_rob_full), .o_tail(w_tail), .o_head(w_head), .o_pop(w_pop),
    .o_head_dest(w_head_dest), .o_head_hasd(w_head_hasd), .o_head_val(w_head_val),
    .o_done_j(w_done_j), .o_done_k(w_done_k), .o_val_j(w_val_j), .o_val_k(w_val_k)
  );

  function automatic opnd_t rd_src(input logic busy, input logic [ROB_IW-1:0] tag,
                                   input logic done, input logic [15:0] rob_v,
                                   input logic [15:0] rf_v, input logic cdbv,
                                   input logic [ROB_IW-1:0] cdbt, input logic [15:0] cdbd);
    opnd_t o;
    o = '{v: '0, q: '0, r: 1'b1};
    if (!busy)                   o.v = rf_v;
    else if (done)               o.v = rob_v;
    else if (cdbv && cdbt == tag) o.v = cdbd;
    else begin o.q = tag; o.r = 1'b0; end
    return o;
  endfunction

  // Operand selection: load/store address is an immediate; load has no k operand.
  always_comb begin
    w_opj = rd_src(r_rf_busy[i_in_rs1], r_rf_tag[i_in_rs1], w_done_j, w_val_j,
                   r_rf_val[i_in_rs1], i_cdb_valid, i_cdb_tag, i_cdb_data);
    w_opk = rd_src(r_rf_busy[w_src_k], r_rf_tag[w_src_k], w_done_k, w_val_k,
                   r_rf_val[w_src_k], i_cdb_valid, i_cdb_tag, i_cdb_data);
    if (w_is_ls) w_opj = '{v: {8'h00, i_in_rs1, i_in_rs2}, q: '0, r: 1'b1};
    if (w_is_ld) w_opk = '{v: '0, q: '0, r: 1'b1};
  end

  // Register file and rename table: commit write first, rename overrides.
  always_ff @(posedge i_clk1) begin
    if (i_rst) begin
      r_rf_val  <= '0;
      r_rf_busy <= '0;
      r_rf_tag  <= '0;
    end else begin
      if (w_commit_wr) begin
        r_rf_val[w_head_dest]  <= w_head_val;
        r_rf_busy[w_head_dest] <= 1'b0;
      end
      if (w_acc && w_hasd) begin
        r_rf_busy[i_in_rd] <= 1'b1;
        r_rf_tag[i_in_rd]  <= w_tail;
      end
    end
  end

  // Per-class occupancy; issue and release together cancel out.
  always_ff @(posedge i_clk1) begin
    if (i_rst) r_cnt <= '0;
    else begin
      for (int c = 0; c < 4; c++) begin
        if (w_inc[c] && !i_release[c])
          r_cnt[c] <= r_cnt[c] + 3'd1;
        else if (!w_inc[c] && i_release[c] && r_cnt[c] != 3'd0)
          r_cnt[c] <= r_cnt[c] - 3'd1;
      end
    end
  end

  // Registered issue, commit and illegal outputs, one cycle after the event.
  always_ff @(posedge i_clk1) begin
    if (i_rst) begin
      o_iss_valid <= 1'b0; o_iss_class <= '0; o_iss_func <= '0; o_iss_rob <= '0;
      o_iss_rd <= '0; o_iss_vj <= '0; o_iss_vk <= '0; o_iss_qj <= '0; o_iss_qk <= '0;
      o_iss_rj <= 1'b0; o_iss_rk <= 1'b0;
      o_commit_valid <= 1'b0; o_commit_rd <= '0; o_commit_data <= '0;
      o_illegal <= 1'b0;
    end else begin
      o_iss_valid    <= w_acc;
      o_illegal      <= i_in_valid & ~w_legal;
      o_commit_valid <= w_pop;
      if (w_acc) begin
        o_iss_class <= w_cls;   o_iss_func <= i_in_func;
        o_iss_rob   <= w_tail;  o_iss_rd   <= i_in_rd;
        o_iss_vj    <= w_opj.v; o_iss_qj   <= w_opj.q; o_iss_rj <= w_opj.r;
        o_iss_vk    <= w_opk.v; o_iss_qk   <= w_opk.q; o_iss_rk <= w_opk.r;
      end
      if (w_pop) begin
        o_commit_rd   <= w_head_dest;
        o_commit_data <= w_head_val;
      end
    end
  end
endmodule

// File: tb/tb_issue_stage.sv
// Self-checking bench for issue_stage: directed table, corner sequences, random vs queue model.
module tb_issue_stage;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, iv, cv;
  logic [3:0]  fn, rs1, rs2, rd, rel;
  logic [2:0]  ct;
  logic [15:0] cd;

  logic        o_in_ready, o_iss_valid, o_iss_rj, o_iss_rk, o_commit_valid, o_illegal;
  logic [1:0]  o_iss_class;
  logic [3:0]  o_iss_func, o_iss_rd, o_commit_rd;
  logic [2:0]  o_iss_rob, o_iss_qj, o_iss_qk;
  logic [15:0] o_iss_vj, o_iss_vk, o_commit_data;

  issue_stage dut (
    .i_clk1(clk), .i_rst(rst), .i_in_valid(iv), .i_in_func(fn), .i_in_rs1(rs1),
    .i_in_rs2(rs2), .i_in_rd(rd), .o_in_ready(o_in_ready), .i_release(rel),
    .i_cdb_valid(cv), .i_cdb_tag(ct), .i_cdb_data(cd),
    .o_iss_valid(o_iss_valid), .o_iss_class(o_iss_class), .o_iss_func(o_iss_func),
    .o_iss_rob(o_iss_rob), .o_iss_rd(o_iss_rd), .o_iss_vj(o_iss_vj), .o_iss_vk(o_iss_vk),
    .o_iss_qj(o_iss_qj), .o_iss_qk(o_iss_qk), .o_iss_rj(o_iss_rj), .o_iss_rk(o_iss_rk),
    .o_commit_valid(o_commit_valid), .o_commit_rd(o_commit_rd),
    .o_commit_data(o_commit_data), .o_illegal(o_illegal)
  );

  int n_tests = 0, n_fail = 0;
  logic smp_ready;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int          tag;
    logic [3:0]  dest;
    bit          hasd;
    bit          done;
    logic [15:0] val;
  } rob_t;

  rob_t        q[$];
  logic [15:0] m_val[16];
  bit          m_busy[16];
  int          m_tag[16];
  int          m_cnt[4];
  int          m_tail;

  bit          e_iv, e_ill, e_cv, e_rj, e_rk;
  logic [1:0]  e_cls;
  logic [3:0]  e_func, e_rd, e_crd;
  logic [2:0]  e_rob, e_qj, e_qk;
  logic [15:0] e_vj, e_vk, e_cdata;

  function automatic int cap(input int c);
    return (c == 2) ? 4 : (c == 3) ? 2 : 3;
  endfunction

  function automatic bit m_ready();
    int c = int'(fn[2:1]);
    return (m_cnt[c] < cap(c)) && (q.size() < 8);
  endfunction

  task automatic m_reset();
    q.delete();
    for (int i = 0; i < 16; i++) begin m_val[i] = '0; m_busy[i] = 0; m_tag[i] = 0; end
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    m_tail = 0;
    e_iv = 0; e_ill = 0; e_cv = 0; e_rj = 0; e_rk = 0; e_cls = '0; e_func = '0;
    e_rd = '0; e_crd = '0; e_rob = '0; e_qj = '0; e_qk = '0;
    e_vj = '0; e_vk = '0; e_cdata = '0;
  endtask

  task automatic rd_op(input logic [3:0] r, output logic [15:0] v, output int qt, output bit rdy);
    bit found;
    found = 0; v = '0; qt = 0; rdy = 1;
    if (!m_busy[r]) v = m_val[r];
    else begin
      foreach (q[i]) if (q[i].tag == m_tag[r] && q[i].done) begin found = 1; v = q[i].val; end
      if (!found) begin
        if (cv && int'(ct) == m_tag[r]) v = cd;
        else begin rdy = 0; qt = m_tag[r]; end
      end
    end
  endtask

  task automatic m_edge();
    int c, qj, qk, d;
    bit legal, acc, hasd, pop, rj, rk;
    logic [15:0] vj, vk;
    if (rst) begin m_reset(); return; end
    c = int'(fn[2:1]);
    legal = !fn[3];
    acc = iv && m_ready() && legal;
    hasd = legal && (c < 2 || fn == 4'd4);
    pop = (q.size() > 0) && q[0].done;
    vj = '0; vk = '0; qj = 0; qk = 0; rj = 1; rk = 1;
    if (c == 2) begin
      vj = {8'h00, rs1, rs2};
      if (fn == 4'd5) rd_op(rd, vk, qk, rk);
    end else begin
      rd_op(rs1, vj, qj, rj);
      rd_op(rs2, vk, qk, rk);
    end
    e_iv = acc; e_ill = iv && !legal; e_cv = pop;
    if (acc) begin
      e_cls = 2'(c); e_func = fn; e_rob = 3'(m_tail); e_rd = rd;
      e_vj = vj; e_vk = vk; e_qj = 3'(qj); e_qk = 3'(qk); e_rj = rj; e_rk = rk;
    end
    if (pop) begin
      e_crd = q[0].dest; e_cdata = q[0].val; d = int'(q[0].dest);
      if (q[0].hasd && m_busy[d] && m_tag[d] == q[0].tag && !(acc && hasd && int'(rd) == d)) begin
        m_val[d] = q[0].val; m_busy[d] = 0;
      end
    end
    if (acc && hasd) begin m_busy[rd] = 1; m_tag[rd] = m_tail; end
    if (cv) foreach (q[i]) if (q[i].tag == int'(ct)) begin q[i].done = 1; q[i].val = cd; end
    if (pop) void'(q.pop_front());
    if (acc) begin
      q.push_back('{tag: m_tail, dest: rd, hasd: hasd, done: 1'b0, val: 16'h0});
      m_tail = (m_tail + 1) % 8;
    end
    for (int k = 0; k < 4; k++) begin
      bit is = acc && (c == k);
      if (is && !rel[k]) m_cnt[k]++;
      else if (!is && rel[k] && m_cnt[k] > 0) m_cnt[k]--;
    end
  endtask

  // One clock: check in_ready before the edge, registered outputs just after.
  task automatic step();
    #3;
    smp_ready = o_in_ready;
    chk("in_ready", {31'b0, o_in_ready}, {31'b0, m_ready()});
    @(posedge clk);
    m_edge();
    #1;
    chk("iss_valid", {31'b0, o_iss_valid}, {31'b0, e_iv});
    chk("illegal", {31'b0, o_illegal}, {31'b0, e_ill});
    chk("commit_valid", {31'b0, o_commit_valid}, {31'b0, e_cv});
    if (e_iv) begin
      chk("iss_ctl", {o_iss_class, o_iss_func, o_iss_rob, o_iss_rd, o_iss_qj, o_iss_qk, o_iss_rj, o_iss_rk},
                     {e_cls, e_func, e_rob, e_rd, e_qj, e_qk, e_rj, e_rk});
      chk("iss_v", {o_iss_vj, o_iss_vk}, {e_vj, e_vk});
    end
    if (e_cv) chk("commit", {o_commit_rd, o_commit_data}, {e_crd, e_cdata});
  endtask

  task automatic drv(input logic v, input logic [3:0] f, input logic [3:0] a, input logic [3:0] b,
                     input logic [3:0] d);
    iv = v; fn = f; rs1 = a; rs2 = b; rd = d;
  endtask

  task automatic do_reset();
    rst = 1; iv = 0; rel = 0; cv = 0; step(); rst = 0;
  endtask

  typedef struct {
    logic iv; logic [3:0] fn, rs1, rs2, rd, rel; logic cv; logic [2:0] ct; logic [15:0] cd;
    logic x_rdy, x_iv, x_ill; logic [1:0] x_cls; logic [2:0] x_rob, x_qj;
    logic [15:0] x_vj; logic x_rj;
  } vec_t;
  vec_t tv[7];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int nd[$];
    rst = 1; iv = 0; fn = 0; rs1 = 0; rs2 = 0; rd = 0; rel = 0; cv = 0; ct = 0; cd = 0;
    repeat (2) @(posedge clk);
    #1;
    m_reset();
    rst = 0;
    chk("rst_ready", {31'b0, o_in_ready}, 32'd1);
    chk("rst_iss", {o_iss_valid, o_iss_class, o_iss_func, o_iss_rob, o_iss_rd, o_iss_qj,
                    o_iss_qk, o_iss_rj, o_iss_rk}, 32'd0);
    chk("rst_v", {o_iss_vj, o_iss_vk}, 32'd0);
    chk("rst_commit", {o_illegal, o_commit_valid, o_commit_rd, o_commit_data}, 32'd0);

    // iv fn rs1 rs2 rd rel cv ct cd | rdy iv ill cls rob qj vj rj
    tv[0] = '{1'b1, 4'h0, 4'h1, 4'h2, 4'h3, 4'h0, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b1, 1'b0, 2'd0, 3'd0, 3'd0, 16'h0000, 1'b1};
    tv[1] = '{1'b1, 4'h1, 4'h3, 4'h1, 4'h4, 4'h0, 1'b1, 3'd0, 16'h0005, 1'b1, 1'b1, 1'b0, 2'd0, 3'd1, 3'd0, 16'h0005, 1'b1};
    tv[2] = '{1'b1, 4'h0, 4'h4, 4'h3, 4'h5, 4'h0, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b1, 1'b0, 2'd0, 3'd2, 3'd1, 16'h0000, 1'b0};
    tv[3] = '{1'b1, 4'h0, 4'h0, 4'h0, 4'h6, 4'h0, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 3'd0, 16'h0000, 1'b0};
    tv[4] = '{1'b1, 4'hA, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b0, 1'b1, 2'd0, 3'd0, 3'd0, 16'h0000, 1'b0};
    tv[5] = '{1'b1, 4'h4, 4'hA, 4'h5, 4'h6, 4'h0, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b1, 1'b0, 2'd2, 3'd3, 3'd0, 16'h00A5, 1'b1};
    tv[6] = '{1'b1, 4'h2, 4'h3, 4'h0, 4'h7, 4'h1, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b1, 1'b0, 2'd1, 3'd4, 3'd0, 16'h0005, 1'b1};
    for (int i = 0; i < 7; i++) begin
      drv(tv[i].iv, tv[i].fn, tv[i].rs1, tv[i].rs2, tv[i].rd);
      rel = tv[i].rel; cv = tv[i].cv; ct = tv[i].ct; cd = tv[i].cd;
      step();
      chk($sformatf("tv%0d_ready", i), {31'b0, smp_ready}, {31'b0, tv[i].x_rdy});
      chk($sformatf("tv%0d_iv", i), {31'b0, o_iss_valid}, {31'b0, tv[i].x_iv});
      chk($sformatf("tv%0d_ill", i), {31'b0, o_illegal}, {31'b0, tv[i].x_ill});
      if (tv[i].x_iv)
        chk($sformatf("tv%0d_fields", i), {o_iss_class, o_iss_rob, o_iss_qj, o_iss_rj, o_iss_vj},
            {tv[i].x_cls, tv[i].x_rob, tv[i].x_qj, tv[i].x_rj, tv[i].x_vj});
    end
    rel = 0; cv = 0;

    // MUL station full until a release pulse.
    do_reset();
    drv(1, 4'h2, 4'h0, 4'h0, 4'h1);
    repeat (3) step();
    step(); chk("mul4_ready", {31'b0, smp_ready}, 32'd0); chk("mul4_iv", {31'b0, o_iss_valid}, 32'd0);
    step(); chk("mul4_hold", {31'b0, smp_ready}, 32'd0);
    rel = 4'b0010; step(); chk("mul4_rel_cycle", {31'b0, smp_ready}, 32'd0);
    rel = 4'b0000; step();
    chk("mul4_after_rel", {31'b0, smp_ready}, 32'd1);
    chk("mul4_issue", {31'b0, o_iss_valid, o_iss_rob}, {28'b0, 1'b1, 3'd3});

    // ROB full, commit does not free same cycle, tail wraps.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drv(1, (i < 3) ? 4'h0 : (i < 6) ? 4'h2 : 4'h6, 4'h0, 4'h0, 4'(i + 1));
      step();
    end
    drv(1, 4'h4, 4'h1, 4'h2, 4'h9);
    step(); chk("rob_full", {31'b0, smp_ready}, 32'd0);
    cv = 1; ct = 3'd0; cd = 16'h1234;
    step(); chk("rob_full_cdb", {31'b0, smp_ready}, 32'd0);
    cv = 0;
    step();
    chk("commit_no_free", {31'b0, smp_ready}, 32'd0);
    chk("commit_seen", {11'b0, o_commit_valid, o_commit_rd, o_commit_data}, {11'b0, 1'b1, 4'h1, 16'h1234});
    step();
    chk("wrap_ready", {31'b0, smp_ready}, 32'd1);
    chk("wrap_issue", {o_iss_valid, o_iss_class, o_iss_rob}, {1'b1, 2'd2, 3'd0});
    iv = 0;

    // Random traffic, including occasional mid-run reset.
    do_reset();
    for (int n = 0; n < 2500; n++) begin
      rst = ($urandom_range(0, 299) == 0);
      drv($urandom_range(0, 9) < 7, {($urandom_range(0, 7) == 0), 3'($urandom)},
          4'($urandom), 4'($urandom), 4'($urandom));
      for (int k = 0; k < 4; k++) rel[k] = ($urandom_range(0, 4) == 0);
      nd.delete();
      foreach (q[i]) if (!q[i].done) nd.push_back(q[i].tag);
      cv = 0;
      if (nd.size() > 0 && $urandom_range(0, 9) < 4) begin
        cv = 1;
        ct = 3'(nd[$urandom_range(0, nd.size() - 1)]);
        cd = 16'($urandom);
      end
      step();
    end
    rst = 0; iv = 0; rel = 0; cv = 0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
